// File: rtl/rv32_mem_pkg.sv
// Shared types for the RV32I memory-port arbiter: FSM encoding, grant IDs and mask width.
package rv32_mem_pkg;

  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBusyIf = 2'd1,
    StBusyLs = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntIf = 1'b0,
    GntLs = 1'b1
  } grant_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles without a memory response and flags the cycle on which the wait expires.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Expire on the TIMEOUT-th waiting cycle so BUSY never lasts longer than TIMEOUT cycles.
  localparam logic [CntW-1:0] LastCnt = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire_o = (TIMEOUT != 0) && enable_i && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store with round-robin
// arbitration, a registered command, response routing and a bounded wait.
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_address,
  input  logic [MASK_W-1:0] if_mask,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              ls_request,
  input  logic              ls_we_re,
  input  logic [ADDR_W-1:0] ls_address,
  input  logic [MASK_W-1:0] ls_mask,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_valid,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [MASK_W-1:0] mem_mask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  grant_e            last_q, last_d, gnt;
  logic              mem_request_q, mem_request_d;
  logic              mem_we_re_q, mem_we_re_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [MASK_W-1:0] mem_mask_q, mem_mask_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic              if_valid_q, if_valid_d, ls_valid_q, ls_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic              if_elig, ls_elig, ctr_clear, ctr_enable, expire;

  // A requester still high during its own completion pulse is not a new request.
  assign if_elig    = if_request & ~if_valid_q;
  assign ls_elig    = ls_request & ~ls_valid_q;
  assign stall      = if_elig | ls_elig;
  assign ctr_enable = (state_q != StIdle) & ~mem_valid;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clear_i (ctr_clear),
    .enable_i(ctr_enable),
    .expire_o(expire)
  );

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt           = GntIf;
    mem_request_d = mem_request_q;
    mem_we_re_d   = mem_we_re_q;
    mem_address_d = mem_address_q;
    mem_mask_d    = mem_mask_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    ls_rdata_d    = ls_rdata_q;
    if_valid_d    = 1'b0;
    ls_valid_d    = 1'b0;
    timeout_err_d = 1'b0;
    ctr_clear     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (if_elig || ls_elig) begin
          if (if_elig && ls_elig) begin
            gnt = (last_q == GntIf) ? GntLs : GntIf;
          end else begin
            gnt = ls_elig ? GntLs : GntIf;
          end
          last_d        = gnt;
          ctr_clear     = 1'b1;
          mem_request_d = 1'b1;
          if (gnt == GntLs) begin
            state_d       = StBusyLs;
            mem_we_re_d   = ls_we_re;
            mem_address_d = ls_address;
            mem_mask_d    = ls_mask;
            mem_wdata_d   = ls_wdata;
          end else begin
            state_d       = StBusyIf;
            mem_we_re_d   = 1'b0;
            mem_address_d = if_address;
            mem_mask_d    = if_mask;
            mem_wdata_d   = '0;
          end
        end
      end
      StBusyIf, StBusyLs: begin
        // expire is gated by ~mem_valid, so a response on the last cycle still completes.
        if (mem_valid || expire) begin
          state_d       = StIdle;
          mem_request_d = 1'b0;
          timeout_err_d = ~mem_valid;
          if (state_q == StBusyIf) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_valid ? mem_rdata : '0;
          end else begin
            ls_valid_d = 1'b1;
            ls_rdata_d = (mem_valid && !mem_we_re_q) ? mem_rdata : '0;
          end
        end
      end
      default: begin
        state_d       = StIdle;
        mem_request_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      last_q        <= GntIf;
      mem_request_q <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_address_q <= '0;
      mem_mask_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      ls_rdata_q    <= '0;
      if_valid_q    <= 1'b0;
      ls_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      mem_request_q <= mem_request_d;
      mem_we_re_q   <= mem_we_re_d;
      mem_address_q <= mem_address_d;
      mem_mask_q    <= mem_mask_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      ls_rdata_q    <= ls_rdata_d;
      if_valid_q    <= if_valid_d;
      ls_valid_q    <= ls_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_request = mem_request_q;
  assign mem_we_re   = mem_we_re_q;
  assign mem_address = mem_address_q;
  assign mem_mask    = mem_mask_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rdata    = if_rdata_q;
  assign ls_rdata    = ls_rdata_q;
  assign if_valid    = if_valid_q;
  assign ls_valid    = ls_valid_q;
  assign timeout_err = timeout_err_q;

endmodule
